// File: rtl/md_if.sv
// Request/response bundle between the issue side (register file read ports)
// and the iterative multiply/divide unit.
interface md_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) ();
    logic             start;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [RADDR-1:0] rd_in;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [RADDR-1:0] rd_out;

    modport master (
        output start, funct3, a, b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, a, b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or
// restoring divide, one sign-fix cycle, one-cycle done strobe.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per cycle, 32 iterations
// FIX   | sign correction and result selection, result registered
// DONE  | done strobe; a new start here is accepted immediately
module md_unit #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [4:0]         iter_left;
    logic [2:0]         op;
    logic [RADDR-1:0]   rd_lat;
    logic               neg_res;
    logic [XLEN-1:0]    acc_hi;     // product high half / partial remainder
    logic [XLEN-1:0]    acc_lo;     // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]    opnd;       // multiplicand or divisor magnitude
    logic               busy_q;
    logic               done_q;
    logic [XLEN-1:0]    result_q;
    logic [RADDR-1:0]   rd_out_q;

    logic               a_abs;
    logic               b_abs;
    logic               neg_in;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic               accept;

    logic [XLEN:0]      mul_sum;
    logic [XLEN+1:0]    div_trial;

    logic [2*XLEN-1:0]  prod;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    fix_res;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    // Operand magnitudes and result sign for the incoming request.
    // A DIV by zero keeps a positive sign so the all-ones quotient survives
    // the fix step; REM by zero needs nothing special, since the remainder
    // magnitude equals |a| and the sign of a restores the original dividend.
    // The signed-overflow case also falls out naturally: |a|=2^31, |b|=1
    // gives quotient 0x80000000 with positive sign and a zero remainder.
    always_comb begin
        a_abs  = 1'b0;
        b_abs  = 1'b0;
        neg_in = 1'b0;
        case (bus.funct3)
            F_MULH: begin
                a_abs  = 1'b1;
                b_abs  = 1'b1;
                neg_in = bus.a[XLEN-1] ^ bus.b[XLEN-1];
            end
            F_MULHSU: begin
                a_abs  = 1'b1;
                neg_in = bus.a[XLEN-1];
            end
            F_DIV: begin
                a_abs  = 1'b1;
                b_abs  = 1'b1;
                neg_in = (bus.b != '0) && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            end
            F_REM: begin
                a_abs  = 1'b1;
                b_abs  = 1'b1;
                neg_in = bus.a[XLEN-1];
            end
            default: ;
        endcase
        mag_a = (a_abs && bus.a[XLEN-1]) ? -bus.a : bus.a;
        mag_b = (b_abs && bus.b[XLEN-1]) ? -bus.b : bus.b;
    end

    // One iteration of the datapath: add-then-shift multiply, trial-subtract divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial = {1'b0, acc_hi, acc_lo[XLEN-1]} - {2'b00, opnd};
    end

    // Sign correction and result selection used in the FIX cycle.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_res ? -acc_hi : acc_hi;
        case (op)
            F_MUL:                    fix_res = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:            fix_res = quo_fix;
            default:                  fix_res = rem_fix;
        endcase
    end

    // Sequencer and datapath registers; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            iter_left <= '0;
            op        <= '0;
            rd_lat    <= '0;
            neg_res   <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            case (state)
                IDLE: ;
                CALC: begin
                    if (op[2]) begin
                        if (!div_trial[XLEN+1]) begin
                            acc_hi <= div_trial[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    end
                    if (iter_left == 5'd0) begin
                        state <= FIX;
                    end else begin
                        iter_left <= iter_left - 5'd1;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    rd_out_q <= rd_lat;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Accept overrides the DONE->IDLE default for back-to-back issue.
            if (accept) begin
                state     <= CALC;
                busy_q    <= 1'b1;
                iter_left <= 5'd31;
                op        <= bus.funct3;
                rd_lat    <= bus.rd_in;
                neg_res   <= neg_in;
                acc_hi    <= '0;
                acc_lo    <= bus.funct3[2] ? mag_a : mag_b;
                opnd      <= bus.funct3[2] ? mag_b : mag_a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: op results, special divides, latency,
// protocol (ignored start, operand changes, back-to-back) and mid-op reset.
module tb_md_unit;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;
    bit   pulses;

    md_if #(.XLEN(32), .RADDR(5)) bus ();

    md_unit #(.XLEN(32), .RADDR(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.a      = a;
        bus.b      = b;
        bus.rd_in  = rd;
    endtask

    // Waits for done starting from the accept edge; lat counts the accept edge as 1.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic [4:0] rdo,
                             output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        res     = '0;
        rdo     = '0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            bus.start  = 1'b0;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.a      = $urandom;
            bus.b      = $urandom;
            bus.rd_in  = 5'($urandom_range(0, 31));
            if (pulses && (lat == 5 || lat == 20)) bus.start = 1'b1;
            if (bus.busy !== (lat <= 33)) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                res = bus.result;
                rdo = bus.rd_out;
                break;
            end
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[] = '{
        '{"mul",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB},
        '{"mulh",     3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd1,  32'h00000000},
        '{"mulhsu",   3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd2,  32'h80000000},
        '{"mulhu",    3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h7FFFFFFF},
        '{"div",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD},
        '{"rem",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF},
        '{"divu",     3'b101, 32'd7,        32'd2,        5'd6,  32'd3},
        '{"remu",     3'b111, 32'd7,        32'd2,        5'd0,  32'd1},
        '{"div0",     3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF},
        '{"rem0",     3'b110, 32'd5,        32'd0,        5'd11, 32'd5},
        '{"divneg0",  3'b100, 32'hFFFFFFFB, 32'd0,        5'd12, 32'hFFFFFFFF},
        '{"remneg0",  3'b110, 32'hFFFFFFFB, 32'd0,        5'd13, 32'hFFFFFFFB},
        '{"divovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000},
        '{"removf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0},
        '{"mulbig",   3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd16, 32'h242D2080}
    };

    initial begin
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        bit          busy_ok;
        bit          seen_done;

        errs   = 0;
        checks = 0;
        pulses = 1'b0;
        rst_n  = 1'b0;
        bus.start = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   bus.busy,   1'b0);
        check("rst_done",   bus.done,   1'b0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd",     bus.rd_out, 5'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            launch(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_done(lat, res, rdo, busy_ok);
            check({vecs[i].tag, "_res"},  res,     vecs[i].exp);
            check({vecs[i].tag, "_rd"},   rdo,     vecs[i].rd);
            check({vecs[i].tag, "_lat"},  lat,     34);
            check({vecs[i].tag, "_busy"}, busy_ok, 1'b1);
        end

        @(posedge clk); #1;
        check("done_strobe", bus.done, 1'b0);
        check("result_hold", bus.result, 32'h242D2080);

        // start pulses while busy are dropped; first op result stands
        pulses = 1'b1;
        @(negedge clk);
        launch(3'b000, 32'd7, 32'hFFFFFFFD, 5'd20);
        wait_done(lat, res, rdo, busy_ok);
        pulses = 1'b0;
        check("ign_res", res, 32'hFFFFFFEB);
        check("ign_rd",  rdo, 5'd20);
        check("ign_lat", lat, 34);
        repeat (40) @(posedge clk);
        #1;
        check("ign_noq", bus.busy, 1'b0);

        // back-to-back: start held during the DONE cycle
        @(negedge clk);
        launch(3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd21);
        wait_done(lat, res, rdo, busy_ok);
        check("b2b1_res", res, 32'h7FFFFFFF);
        launch(3'b101, 32'd7, 32'd2, 5'd22);
        wait_done(lat, res, rdo, busy_ok);
        check("b2b2_res",  res,     32'd3);
        check("b2b2_rd",   rdo,     5'd22);
        check("b2b2_lat",  lat,     34);
        check("b2b2_busy", busy_ok, 1'b1);

        // reset during an op
        @(negedge clk);
        launch(3'b101, 32'd1000, 32'd3, 5'd7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy",   bus.busy,   1'b0);
        check("mrst_done",   bus.done,   1'b0);
        check("mrst_result", bus.result, 32'd0);
        check("mrst_rd",     bus.rd_out, 5'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("mrst_nodone", seen_done, 1'b0);

        @(negedge clk);
        launch(3'b101, 32'd100, 32'd7, 5'd8);
        wait_done(lat, res, rdo, busy_ok);
        check("post_res", res, 32'd14);
        check("post_rd",  rdo, 5'd8);
        check("post_lat", lat, 34);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
